pulse_tx_hs: RTL

PULSE_TX_HS -- requirements
Module: pulse_tx_hs

---
 rtl/pulse_tx_hs.sv | 83 ++++++++
 1 files changed

// File: rtl/pulse_tx_hs.sv
// Event-pulse transmitter: counts single-cycle events and launches each as one
// four-phase return-to-zero req/ack handshake toward an asynchronous receiver.
module pulse_tx_hs #(
  parameter int unsigned PEND_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              ack_in,
  output logic              req,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                req_q, req_d;
  logic                busy_q, busy_d;
  logic                overflow_q, overflow_d;
  logic                ack_s1_q, ack_sync_q;
  logic                launch;

  // Next-state, pending-count and registered-output logic.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    overflow_d = 1'b0;
    launch     = (state_q == IDLE) && ((pend_q != '0) || pulse_in);

    unique case (state_q)
      IDLE:    if (launch)      state_d = REQ_HI;
      REQ_HI:  if (ack_sync_q)  state_d = REQ_LO;
      REQ_LO:  if (!ack_sync_q) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase

    // A pulse arriving in the launch cycle replaces the launched event: no change.
    if (pulse_in && !launch) begin
      if (pend_q == PEND_MAX) overflow_d = 1'b1;
      else                    pend_d     = pend_q + PEND_W'(1);
    end else if (!pulse_in && launch) begin
      pend_d = pend_q - PEND_W'(1);
    end

    req_d  = (state_d == REQ_HI);
    busy_d = (state_d != IDLE) || (pend_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      ack_s1_q   <= 1'b0;
      ack_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      ack_s1_q   <= ack_in;
      ack_sync_q <= ack_s1_q;
    end
  end

  assign req      = req_q;
  assign busy     = busy_q;
  assign pend_cnt = pend_q;
  assign overflow = overflow_q;

endmodule
